// File: rtl/dmem_lsu_bridge.sv
// LSU req/gnt/rvalid port to single-port data RAM bridge with decode, error responses and profiling counters.
// Optional random grant stalls are enabled by defining DMEM_BRIDGE_STALL_EN.
module dmem_lsu_bridge #(
    parameter int          ADDR_W     = 13,
    parameter int          SIZE_WORDS = 8192,
    parameter logic [31:0] BASE_ADDR  = 32'h0010_0000
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              data_req_i,
    output logic              data_gnt_o,
    input  logic [31:0]       data_addr_i,
    input  logic              data_we_i,
    input  logic [3:0]        data_be_i,
    input  logic [31:0]       data_wdata_i,
    output logic              data_rvalid_o,
    output logic [31:0]       data_rdata_o,
    output logic              data_err_o,
    output logic              ram_cs_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_wmask_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i,
    output logic [31:0]       rd_cnt_o,
    output logic [31:0]       wr_cnt_o,
    output logic [31:0]       err_cnt_o
);

    localparam logic [32:0] SPAN_BYTES = 33'(SIZE_WORDS) * 33'd4;

    typedef enum logic {IDLE, RESP} state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    state_t      state_q, state_d;
    logic        resp_err_q, resp_err_d;
    logic        resp_we_q, resp_we_d;
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;
    logic [31:0] err_cnt_q, err_cnt_d;

    logic        stall;
    logic [31:0] off;
    logic        in_range;
    logic        be_legal;
    logic        gnt;
    logic        accept;

`ifdef DMEM_BRIDGE_STALL_EN
    // Fibonacci LFSR x^8+x^6+x^5+x^4+1; stalls roughly one cycle in four.
    logic [7:0] lfsr_q, lfsr_d;

    always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) lfsr_q <= 8'hA5;
        else          lfsr_q <= lfsr_d;
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    assign off      = data_addr_i - BASE_ADDR;
    assign in_range = (data_addr_i >= BASE_ADDR) && ({1'b0, off} < SPAN_BYTES);

    always_comb begin
        case (data_be_i)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b0110, 4'b1100, 4'b1111: be_legal = 1'b1;
            default:                            be_legal = 1'b0;
        endcase
    end

    // Reset gates the grant so nothing reaches the RAM while HRESETn is low.
    assign gnt    = data_req_i & ~stall & HRESETn;
    assign accept = gnt & in_range & be_legal;

    assign data_gnt_o  = gnt;
    assign ram_cs_o    = accept;
    assign ram_we_o    = accept & data_we_i;
    assign ram_addr_o  = off[ADDR_W+1:2];
    assign ram_wdata_o = data_wdata_i;

    always_comb begin
        ram_wmask_o = '0;
        for (int i = 0; i < 4; i++) ram_wmask_o[8*i +: 8] = {8{data_be_i[i]}};
    end

    always_comb begin
        state_d    = gnt ? RESP : IDLE;
        resp_err_d = resp_err_q;
        resp_we_d  = resp_we_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (gnt) begin
            resp_err_d = ~accept;
            resp_we_d  = data_we_i;
        end
        if (accept && !data_we_i) rd_cnt_d  = sat_inc(rd_cnt_q);
        if (accept && data_we_i)  wr_cnt_d  = sat_inc(wr_cnt_q);
        if (gnt && !accept)       err_cnt_d = sat_inc(err_cnt_q);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= IDLE;
            resp_err_q <= 1'b0;
            resp_we_q  <= 1'b0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            resp_err_q <= resp_err_d;
            resp_we_q  <= resp_we_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // RAM read data lands in the RESP cycle, so it is passed through unregistered.
    assign data_rvalid_o = (state_q == RESP);
    assign data_err_o    = (state_q == RESP) & resp_err_q;
    assign data_rdata_o  = ((state_q == RESP) && !resp_err_q && !resp_we_q) ? ram_rdata_i : 32'd0;

    assign rd_cnt_o  = rd_cnt_q;
    assign wr_cnt_o  = wr_cnt_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_dmem_lsu_bridge.sv
// Directed self-checking bench for dmem_lsu_bridge with a behavioural single-port RAM.
module tb_dmem_lsu_bridge;

    localparam logic [31:0] BASE = 32'h0010_0000;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        data_req_i, data_gnt_o, data_we_i;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic [3:0]  data_be_i;
    logic        data_rvalid_o, data_err_o;
    logic        ram_cs_o, ram_we_o;
    logic [12:0] ram_addr_o;
    logic [31:0] ram_wmask_o, ram_wdata_o, ram_rdata_i;
    logic [31:0] rd_cnt_o, wr_cnt_o, err_cnt_o;

    logic [31:0] mem [0:8191];
    int n_assert = 0;
    int n_fail   = 0;

    always #5 HCLK = ~HCLK;

    dmem_lsu_bridge dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_addr_i(data_addr_i),
        .data_we_i(data_we_i), .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .ram_cs_o(ram_cs_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_wmask_o(ram_wmask_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
        .rd_cnt_o(rd_cnt_o), .wr_cnt_o(wr_cnt_o), .err_cnt_o(err_cnt_o)
    );

    // Behavioural RAM: masked write at the edge, registered read one cycle after cs.
    always @(posedge HCLK) begin
        if (ram_cs_o) begin
            if (ram_we_o) mem[ram_addr_o] <= (mem[ram_addr_o] & ~ram_wmask_o) | (ram_wdata_o & ram_wmask_o);
            else          ram_rdata_i <= mem[ram_addr_o];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        @(negedge HCLK);
        data_req_i   = req;
        data_we_i    = we;
        data_addr_i  = addr;
        data_be_i    = be;
        data_wdata_i = wd;
        #1;
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

`ifdef DMEM_BRIDGE_STALL_EN
    logic [7:0] lfsr_m;
    int         rv_cnt = 0;
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) lfsr_m <= 8'hA5;
        else          lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end
    always @(posedge HCLK) if (HRESETn && data_rvalid_o) rv_cnt++;
`endif

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 32'd0;
        mem[5]      = 32'hDEAD_BEEF;
        ram_rdata_i = 32'd0;
        HRESETn     = 1'b0;
        data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = BASE;
        data_be_i = 4'hF; data_wdata_i = 32'h5555_5555;
        tick();
        @(negedge HCLK); #1;
        check("rst_gnt", data_gnt_o, 1'b0);
        check("rst_cs", ram_cs_o, 1'b0);
        check("rst_we", ram_we_o, 1'b0);
        check("rst_rvalid", data_rvalid_o, 1'b0);
        check("rst_err", data_err_o, 1'b0);
        check("rst_rdata", data_rdata_o, 32'd0);
        check("rst_rdcnt", rd_cnt_o, 32'd0);
        check("rst_wrcnt", wr_cnt_o, 32'd0);
        check("rst_errcnt", err_cnt_o, 32'd0);
        drive(1'b0, 1'b0, BASE, 4'hF, 32'd0);
        HRESETn = 1'b1;
        tick();
        check("idle_rvalid", data_rvalid_o, 1'b0);

`ifndef DMEM_BRIDGE_STALL_EN
        // Load word 5
        drive(1'b1, 1'b0, BASE + 32'h14, 4'hF, 32'd0);
        check("ld_gnt", data_gnt_o, 1'b1);
        check("ld_cs", ram_cs_o, 1'b1);
        check("ld_we", ram_we_o, 1'b0);
        check("ld_addr", ram_addr_o, 13'd5);
        tick();
        check("ld_rvalid", data_rvalid_o, 1'b1);
        check("ld_rdata", data_rdata_o, 32'hDEAD_BEEF);
        check("ld_err", data_err_o, 1'b0);
        check("ld_rdcnt", rd_cnt_o, 32'd1);

        // Byte store then back-to-back load of the same word
        drive(1'b1, 1'b1, BASE + 32'h14, 4'b0100, 32'h00AB_0000);
        check("st_gnt", data_gnt_o, 1'b1);
        check("st_cs", ram_cs_o, 1'b1);
        check("st_we", ram_we_o, 1'b1);
        check("st_mask", ram_wmask_o, 32'h00FF_0000);
        check("st_wdata", ram_wdata_o, 32'h00AB_0000);
        tick();
        check("st_rvalid", data_rvalid_o, 1'b1);
        check("st_rdata", data_rdata_o, 32'd0);
        drive(1'b1, 1'b0, BASE + 32'h14, 4'hF, 32'd0);
        check("ld2_gnt", data_gnt_o, 1'b1);
        tick();
        check("ld2_rvalid", data_rvalid_o, 1'b1);
        check("ld2_rdata", data_rdata_o, 32'hDEAB_BEEF);
        check("ld2_wrcnt", wr_cnt_o, 32'd1);
        check("ld2_rdcnt", rd_cnt_o, 32'd2);

        // Rejected accesses: illegal be, past the end, below the base
        drive(1'b1, 1'b0, BASE, 4'b0101, 32'd0);
        check("ilbe_gnt", data_gnt_o, 1'b1);
        check("ilbe_cs", ram_cs_o, 1'b0);
        tick();
        check("ilbe_rvalid", data_rvalid_o, 1'b1);
        check("ilbe_err", data_err_o, 1'b1);
        check("ilbe_rdata", data_rdata_o, 32'd0);
        drive(1'b1, 1'b1, BASE + 32'h8000, 4'hF, 32'hFFFF_FFFF);
        check("oor_gnt", data_gnt_o, 1'b1);
        check("oor_cs", ram_cs_o, 1'b0);
        tick();
        check("oor_err", data_err_o, 1'b1);
        check("oor_rdata", data_rdata_o, 32'd0);
        drive(1'b1, 1'b0, BASE - 32'd4, 4'hF, 32'd0);
        check("low_cs", ram_cs_o, 1'b0);
        tick();
        check("low_err", data_err_o, 1'b1);
        check("rej_errcnt", err_cnt_o, 32'd3);
        check("rej_mem0", mem[0], 32'd0);
        check("rej_mem5", mem[5], 32'hDEAB_BEEF);

        // Last in-range word with a halfword enable
        mem[8191] = 32'h1234_5678;
        drive(1'b1, 1'b0, BASE + 32'h7FFE, 4'b1100, 32'd0);
        check("last_cs", ram_cs_o, 1'b1);
        check("last_addr", ram_addr_o, 13'h1FFF);
        check("last_mask", ram_wmask_o, 32'hFFFF_0000);
        tick();
        check("last_err", data_err_o, 1'b0);
        check("last_rdata", data_rdata_o, 32'h1234_5678);
        drive(1'b0, 1'b0, BASE, 4'hF, 32'd0);
        tick();
        check("gap_rvalid", data_rvalid_o, 1'b0);

        // 16 back-to-back requests, each load reads the word stored the cycle before
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) drive(1'b1, 1'b1, BASE + 32'(4 * (20 + i)), 4'hF, 32'h1000_0000 + 32'(i));
            else            drive(1'b1, 1'b0, BASE + 32'(4 * (19 + i)), 4'hF, 32'd0);
            check("b2b_gnt", data_gnt_o, 1'b1);
            tick();
            check("b2b_rvalid", data_rvalid_o, 1'b1);
            check("b2b_rdata", data_rdata_o, (i % 2 == 0) ? 32'd0 : 32'h1000_0000 + 32'(i - 1));
        end
        drive(1'b0, 1'b0, BASE, 4'hF, 32'd0);
        tick();
        check("b2b_tail_rvalid", data_rvalid_o, 1'b0);
        check("b2b_rdcnt", rd_cnt_o, 32'd11);
        check("b2b_wrcnt", wr_cnt_o, 32'd9);
        check("b2b_errcnt", err_cnt_o, 32'd3);

        // Reset right after a grant drops the pending response
        drive(1'b1, 1'b0, BASE + 32'h14, 4'hF, 32'd0);
        tick();
        HRESETn = 1'b0;
        data_we_i = 1'b1; data_addr_i = BASE; data_wdata_i = 32'hCAFE_F00D;
        #1;
        check("mid_rst_rvalid", data_rvalid_o, 1'b0);
        check("mid_rst_gnt", data_gnt_o, 1'b0);
        check("mid_rst_cs", ram_cs_o, 1'b0);
        tick();
        drive(1'b0, 1'b0, BASE, 4'hF, 32'd0);
        HRESETn = 1'b1;
        tick();
        check("post_rst_rvalid", data_rvalid_o, 1'b0);
        check("post_rst_rdcnt", rd_cnt_o, 32'd0);
        check("post_rst_wrcnt", wr_cnt_o, 32'd0);
        check("post_rst_errcnt", err_cnt_o, 32'd0);
        check("post_rst_mem0", mem[0], 32'd0);
`else
        // 200 loads, each held until granted; grant must follow the LFSR model
        for (int r = 0; r < 200; r++) begin
            logic granted;
            granted = 1'b0;
            drive(1'b1, 1'b0, BASE + 32'(4 * (r % 16)), 4'hF, 32'd0);
            for (int w = 0; w < 64 && !granted; w++) begin
                check("stall_gnt", data_gnt_o, (lfsr_m[1:0] != 2'b00));
                if (data_gnt_o) granted = 1'b1;
                tick();
                if (!granted) begin
                    @(negedge HCLK);
                    #1;
                end
            end
            check("stall_granted", granted, 1'b1);
        end
        drive(1'b0, 1'b0, BASE, 4'hF, 32'd0);
        tick();
        tick();
        check("stall_rvalids", rv_cnt, 32'd200);
        check("stall_rdcnt", rd_cnt_o, 32'd200);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_lsu_bridge.md
# dmem_lsu_bridge

Bridge between the Zero-riscy LSU data port (req/gnt/rvalid protocol) and the single-port data RAM (word address, 32-bit lane mask, chip select, one-cycle registered read). Decodes and range-checks byte addresses, expands byte enables to a lane mask, rejects illegal accesses with an error response, returns one rvalid per granted transaction, and keeps access counters for profiling. Sits directly upstream of the data RAM in the ZeroRiscy test bench.

## Interface
Parameters:
- ADDR_W, 13, RAM word-address width
- SIZE_WORDS, 8192, RAM depth in 32-bit words
- BASE_ADDR, 32'h0010_0000, byte address mapped to RAM word 0; must be word-aligned

Ports:
- HCLK  in  1  clock; all state updates on posedge
- HRESETn  in  1  reset, asynchronous, active-low
- data_req_i  in  1  LSU request, held until granted
- data_gnt_o  out  1  grant, combinational
- data_addr_i  in  32  byte address; bits [1:0] ignored
- data_we_i  in  1  1 = store
- data_be_i  in  4  byte enables, bit i = lane i
- data_wdata_i  in  32  store data, lane-aligned
- data_rvalid_o  out  1  response valid
- data_rdata_o  out  32  load data, lane-aligned, unused lanes 0
- data_err_o  out  1  error flag, qualified by data_rvalid_o
- ram_cs_o, ram_we_o  out  1 each  RAM select / write
- ram_addr_o  out  ADDR_W  RAM word address
- ram_wmask_o  out  32  lane mask
- ram_wdata_o  out  32  RAM write data
- ram_rdata_i  in  32  RAM read data, valid cycle after cs
- rd_cnt_o, wr_cnt_o, err_cnt_o  out  32 each  saturating counters

## Operation
- Grant: data_gnt_o = data_req_i & ~stall. Without stall injection every request is granted in its request cycle; back-to-back grants permitted.
- Decode: off = data_addr_i − BASE_ADDR (32-bit wrap). In range iff data_addr_i ≥ BASE_ADDR and off < 4·SIZE_WORDS. ram_addr_o = off[ADDR_W+1:2].
- Legal data_be_i: 0001, 0010, 0100, 1000, 0011, 0110, 1100, 1111. All others, including 0000, are illegal.
- Mask: ram_wmask_o byte lane i = 8'hFF iff data_be_i[i].
- Accepted access (granted, in range, legal be): ram_cs_o = 1, ram_we_o = data_we_i, ram_wdata_o = data_wdata_i, all in the grant cycle.
- Rejected access (granted, out of range or illegal be): ram_cs_o = 0. Response has data_err_o = 1, data_rdata_o = 0.
- Response FSM (per cycle, no storage beyond one entry): states IDLE, RESP. Any grant -> RESP next cycle; in RESP with no new grant -> IDLE. resp_err and resp_we registered with grant.
- Response data: data_rdata_o = ram_rdata_i when RESP & ~resp_err & ~resp_we; otherwise 0. Stores return rvalid with rdata 0.
- Counters increment on grant: rd_cnt_o for accepted loads, wr_cnt_o for accepted stores, err_cnt_o for rejected accesses. Each saturates at 32'hFFFF_FFFF.
- While HRESETn low: data_gnt_o = 0, ram_cs_o = 0.

## Timing
- Reset values: data_rvalid_o 0, data_err_o 0, data_rdata_o 0, all counters 0, FSM IDLE, ram_cs_o/ram_we_o 0.
- Latency: grant cycle N -> data_rvalid_o cycle N+1, exactly one rvalid per grant, in order.
- Grant cycle N+1 may coincide with response for N. RAM outputs and gnt are then live together.
- Reset asserted mid-transaction: pending response dropped, no rvalid after release. No RAM write in a cycle with HRESETn low.
- Store followed by load to same word in consecutive cycles: load returns new data because RAM write completes at grant-cycle edge.

## Configuration
- DMEM_BRIDGE_STALL_EN defined: 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, reset seed 8'hA5, advances every cycle. stall = (lfsr[1:0] == 2'b00). When stalled, data_gnt_o = 0 and ram_cs_o = 0. The request stays pending and is not counted.
- Undefined: stall tied 0, LFSR absent, zero-wait grant.

## Test plan
- Load word: RAM word 5 = 32'hDEADBEEF; req addr BASE+0x14, be 1111 -> gnt same cycle, next cycle rvalid, rdata 32'hDEADBEEF, err 0, rd_cnt 1.
- Byte store then load: store be 0100 wdata 32'h00AB0000 to BASE+0x14, then load be 1111 back-to-back -> rdata 32'hDEAB BEEF (ram_wmask_o 32'h00FF0000 on store), wr_cnt 1.
- Illegal be 0101 and address BASE+0x8000 -> both granted, ram_cs_o 0, rvalid with err 1, rdata 0, err_cnt 2, RAM unchanged.
- Continuous req for 16 cycles alternating load/store -> 16 grants, 16 rvalids each one cycle later, counters sum to 16.
- Reset asserted the cycle after a grant -> no rvalid after release, all counters 0.
- With DMEM_BRIDGE_STALL_EN: 200 requests -> stalls match LFSR model from seed 8'hA5, every request eventually granted, exactly 200 rvalids.
